// File: rtl/fc_tcdm_apb_bridge_pkg.sv
// Shared types and constants for the FC TCDM-to-APB bridge.
// The state encoding is fixed at 2 bits so it can be traced directly on the bus.
package fc_tcdm_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } bridge_state_e;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned BE_WIDTH           = DEFAULT_DATA_WIDTH / 8;

endpackage

// File: rtl/fc_tcdm_apb_bridge.sv
// Terminates one TCDM request at a time and replays it as a single APB transfer,
// returning the read data or a bus error (PSLVERR or ACCESS-phase timeout) as a one-cycle response.
module fc_tcdm_apb_bridge
    import fc_tcdm_apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      tcdm_req_i,
    input  logic [ADDR_WIDTH-1:0]     tcdm_add_i,
    input  logic                      tcdm_wen_i,
    input  logic [DATA_WIDTH-1:0]     tcdm_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]   tcdm_be_i,
    output logic                      tcdm_gnt_o,
    output logic                      tcdm_r_valid_o,
    output logic [DATA_WIDTH-1:0]     tcdm_r_rdata_o,
    output logic                      tcdm_r_opc_o,
    output logic [ADDR_WIDTH-1:0]     apb_paddr_o,
    output logic [DATA_WIDTH-1:0]     apb_pwdata_o,
    output logic                      apb_pwrite_o,
    output logic [DATA_WIDTH/8-1:0]   apb_pstrb_o,
    output logic                      apb_psel_o,
    output logic                      apb_penable_o,
    input  logic [DATA_WIDTH-1:0]     apb_prdata_i,
    input  logic                      apb_pready_i,
    input  logic                      apb_pslverr_i
);

    localparam int unsigned BW    = DATA_WIDTH / 8;
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    bridge_state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic                  pwrite_q;
    logic [BW-1:0]         pstrb_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  opc_q;
    logic [CNT_W-1:0]      cnt_q;

    logic gnt;
    logic psel;
    logic penable;
    logic r_valid;
    logic timeout_hit;

    // The last timeout cycle only matters when the feature is enabled.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt     = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        r_valid = 1'b0;
        case (state_q)
            IDLE: begin
                gnt = tcdm_req_i;
                if (tcdm_req_i) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                psel    = 1'b1;
                state_d = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (apb_pready_i || timeout_hit) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                r_valid = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // APB request fields are loaded only on grant, so they stay stable through ACCESS and idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            pstrb_q  <= '0;
        end else if (state_q == IDLE && tcdm_req_i) begin
            paddr_q  <= tcdm_add_i;
            pwdata_q <= tcdm_wdata_i;
            pwrite_q <= ~tcdm_wen_i;
            pstrb_q  <= tcdm_wen_i ? '0 : tcdm_be_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (state_q == SETUP) begin
            cnt_q <= '0;
        end else if (state_q == ACCESS && cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // A real PREADY takes priority over a timeout landing on the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
            opc_q   <= 1'b0;
        end else if (state_q == ACCESS) begin
            if (apb_pready_i) begin
                rdata_q <= pwrite_q ? '0 : apb_prdata_i;
                opc_q   <= apb_pslverr_i;
            end else if (timeout_hit) begin
                rdata_q <= '0;
                opc_q   <= 1'b1;
            end
        end
    end

    assign tcdm_gnt_o     = gnt;
    assign tcdm_r_valid_o = r_valid;
    assign tcdm_r_rdata_o = rdata_q;
    assign tcdm_r_opc_o   = opc_q;
    assign apb_paddr_o    = paddr_q;
    assign apb_pwdata_o   = pwdata_q;
    assign apb_pwrite_o   = pwrite_q;
    assign apb_pstrb_o    = pstrb_q;
    assign apb_psel_o     = psel;
    assign apb_penable_o  = penable;

endmodule

// File: tb/tb_fc_tcdm_apb_bridge.sv
// Directed bench for the FC TCDM-to-APB bridge, built with a 4-cycle ACCESS timeout.
// Inputs change 2 time units after the rising edge and outputs are sampled 1 unit later.
module tb_fc_tcdm_apb_bridge;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [31:0] add;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        gnt;
    logic        r_valid;
    logic [31:0] r_rdata;
    logic        r_opc;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic [3:0]  pstrb;
    logic        psel;
    logic        penable;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int checks = 0;
    int errors = 0;

    fc_tcdm_apb_bridge #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .tcdm_req_i    (req),
        .tcdm_add_i    (add),
        .tcdm_wen_i    (wen),
        .tcdm_wdata_i  (wdata),
        .tcdm_be_i     (be),
        .tcdm_gnt_o    (gnt),
        .tcdm_r_valid_o(r_valid),
        .tcdm_r_rdata_o(r_rdata),
        .tcdm_r_opc_o  (r_opc),
        .apb_paddr_o   (paddr),
        .apb_pwdata_o  (pwdata),
        .apb_pwrite_o  (pwrite),
        .apb_pstrb_o   (pstrb),
        .apb_psel_o    (psel),
        .apb_penable_o (penable),
        .apb_prdata_i  (prdata),
        .apb_pready_i  (pready),
        .apb_pslverr_i (pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [11:0] gnt_seen;
    logic [11:0] rv_seen;
    int          pen_cnt;
    int          rv_cycle;

    initial begin
        rst_n   = 1'b0;
        req     = 1'b0;
        add     = '0;
        wen     = 1'b1;
        wdata   = '0;
        be      = '0;
        prdata  = '0;
        pready  = 1'b0;
        pslverr = 1'b0;
        #3;
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_rvalid", r_valid, 0);
        check("rst_paddr", paddr, 0);
        check("rst_rdata", r_rdata, 0);
        check("rst_opc", r_opc, 0);
        #22;
        rst_n = 1'b1;

        // Read, zero wait states
        tick();
        req = 1'b1; add = 32'h1A10_4000; wen = 1'b1; prdata = 32'hDEAD_BEEF; pready = 1'b1;
        #1;
        check("rd_gnt_c0", gnt, 1);
        check("rd_psel_c0", psel, 0);
        tick();
        req = 1'b0;
        #1;
        check("rd_gnt_c1", gnt, 0);
        check("rd_psel_c1", psel, 1);
        check("rd_penable_c1", penable, 0);
        check("rd_paddr", paddr, 32'h1A10_4000);
        check("rd_pwrite", pwrite, 0);
        check("rd_pstrb", pstrb, 0);
        tick();
        #1;
        check("rd_psel_c2", psel, 1);
        check("rd_penable_c2", penable, 1);
        check("rd_rvalid_c2", r_valid, 0);
        tick();
        #1;
        check("rd_rvalid_c3", r_valid, 1);
        check("rd_rdata", r_rdata, 32'hDEAD_BEEF);
        check("rd_opc", r_opc, 0);
        check("rd_psel_c3", psel, 0);
        tick();
        prdata = 32'h0;
        #1;
        check("rd_rvalid_c4", r_valid, 0);
        check("rd_rdata_hold", r_rdata, 32'hDEAD_BEEF);
        check("rd_paddr_hold", paddr, 32'h1A10_4000);

        // Write, three wait states; last one coincides with the timeout cycle
        tick();
        req = 1'b1; add = 32'h1A10_4008; wen = 1'b0; wdata = 32'h1234_5678; be = 4'b0110;
        prdata = 32'hFFFF_FFFF; pready = 1'b0;
        #1;
        check("wr_gnt_c0", gnt, 1);
        tick();
        req = 1'b0; wdata = 32'hAAAA_AAAA; be = 4'b1111;
        #1;
        check("wr_pwrite", pwrite, 1);
        check("wr_pstrb", pstrb, 4'b0110);
        check("wr_pwdata_c1", pwdata, 32'h1234_5678);
        check("wr_paddr", paddr, 32'h1A10_4008);
        for (int c = 2; c <= 5; c++) begin
            tick();
            if (c == 5) pready = 1'b1;
            #1;
            check("wr_penable", penable, 1);
            check("wr_pwdata_stable", pwdata, 32'h1234_5678);
            check("wr_rvalid_early", r_valid, 0);
        end
        tick();
        pready = 1'b0;
        #1;
        check("wr_rvalid_c6", r_valid, 1);
        check("wr_rdata", r_rdata, 0);
        check("wr_opc", r_opc, 0);

        // Read with PSLVERR
        tick();
        req = 1'b1; add = 32'h1A10_4010; wen = 1'b1; prdata = 32'hCAFE_0001;
        pready = 1'b1; pslverr = 1'b1;
        #1;
        check("err_gnt", gnt, 1);
        tick();
        req = 1'b0;
        tick();
        tick();
        #1;
        check("err_rvalid", r_valid, 1);
        check("err_opc", r_opc, 1);
        check("err_rdata", r_rdata, 32'hCAFE_0001);
        tick();
        pslverr = 1'b0;

        // Back-to-back reads with req held high
        tick();
        req = 1'b1; add = 32'h1A10_4020; wen = 1'b1; prdata = 32'h0000_0A5A; pready = 1'b1;
        gnt_seen = '0;
        rv_seen  = '0;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) tick();
            #1;
            gnt_seen[c] = gnt;
            rv_seen[c]  = r_valid;
        end
        tick();
        req = 1'b0;
        #1;
        check("b2b_gnt_pattern", gnt_seen, 12'b0001_0001_0001);
        check("b2b_rvalid_pattern", rv_seen, 12'b1000_1000_1000);
        check("b2b_rdata", r_rdata, 32'h0000_0A5A);
        check("b2b_opc", r_opc, 0);

        // Timeout: PREADY never arrives
        tick();
        req = 1'b1; add = 32'h1A10_4030; wen = 1'b1; prdata = 32'h7777_7777; pready = 1'b0;
        #1;
        check("to_gnt", gnt, 1);
        pen_cnt  = 0;
        rv_cycle = -1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) req = 1'b0;
            #1;
            if (penable) pen_cnt++;
            if (r_valid && rv_cycle < 0) begin
                rv_cycle = c;
                check("to_opc", r_opc, 1);
                check("to_rdata", r_rdata, 0);
                check("to_psel_resp", psel, 0);
            end
        end
        check("to_penable_cycles", pen_cnt, 4);
        check("to_rvalid_cycle", rv_cycle, 6);

        // Asynchronous reset during ACCESS
        tick();
        req = 1'b1; add = 32'h1A10_4040; wen = 1'b1; pready = 1'b0;
        tick();
        req = 1'b0;
        tick();
        #1;
        check("ar_penable_before", penable, 1);
        rst_n = 1'b0;
        #1;
        check("ar_psel", psel, 0);
        check("ar_penable", penable, 0);
        check("ar_rvalid", r_valid, 0);
        check("ar_paddr", paddr, 0);
        #1;
        rst_n = 1'b1;
        tick();
        #1;
        check("ar_no_resp_psel", psel, 0);
        check("ar_no_resp_rvalid", r_valid, 0);
        tick();
        req = 1'b1; add = 32'h1A10_4050; prdata = 32'h0000_55AA; pready = 1'b1;
        #1;
        check("ar_regrant", gnt, 1);
        tick();
        req = 1'b0;
        tick();
        tick();
        #1;
        check("ar_rvalid_after", r_valid, 1);
        check("ar_rdata_after", r_rdata, 32'h0000_55AA);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fc_tcdm_apb_bridge.md
Name: fc_tcdm_apb_bridge

Overview:
TCDM-protocol responder that terminates a core-side XBAR_TCDM_BUS request (req/gnt, then r_valid) and converts it into a single APB3/APB4 transfer toward FC-local peripherals. It sits between the FC data-side demux and the peripheral APB segment, so core loads and stores to peripheral space complete with variable latency. It handles one outstanding transaction at a time, with a bus-error response on PSLVERR or timeout.

Parameters:
ADDR_WIDTH, 32, TCDM/APB address width
DATA_WIDTH, 32, data width; BE width = DATA_WIDTH/8
TIMEOUT_CYCLES, 256, maximum ACCESS-phase cycles before an error is forced; 0 disables the timeout

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
tcdm_req_i  in  1  request valid
tcdm_add_i  in  ADDR_WIDTH  byte address
tcdm_wen_i  in  1  1 = read, 0 = write
tcdm_wdata_i  in  DATA_WIDTH  write data
tcdm_be_i  in  DATA_WIDTH/8  byte enables
tcdm_gnt_o  out  1  request accepted
tcdm_r_valid_o  out  1  response valid, one-cycle pulse
tcdm_r_rdata_o  out  DATA_WIDTH  read data
tcdm_r_opc_o  out  1  1 = error response
apb_paddr_o  out  ADDR_WIDTH  APB address
apb_pwdata_o  out  DATA_WIDTH  APB write data
apb_pwrite_o  out  1  APB direction
apb_pstrb_o  out  DATA_WIDTH/8  write strobes; 0 for reads
apb_psel_o  out  1  select
apb_penable_o  out  1  enable
apb_prdata_i  in  DATA_WIDTH  read data
apb_pready_i  in  1  ready
apb_pslverr_i  in  1  slave error

Behaviour:
- Reset: asynchronous, active-low, one clock. All outputs 0 and FSM = IDLE. A reset mid-transfer drops PSEL immediately. No response is issued for the aborted request.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - tcdm_gnt_o = tcdm_req_i (combinational, only in IDLE).
  - On req&gnt, register addr, ~wen, wdata and be into paddr, pwrite, pwdata and pstrb. pstrb = be when writing, else 0.
  - Next state SETUP.
- SETUP: psel=1, penable=0, held for exactly one cycle. Next state ACCESS. The timeout counter clears to 0.
- ACCESS:
  - psel=1, penable=1; the counter increments every cycle.
  - pready=1: capture prdata (forced to 0 for writes) into r_rdata and pslverr into r_opc, then go to RESP.
  - If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1 without pready: leave ACCESS anyway, with r_rdata=0, r_opc=1, then RESP.
  - pready and the last timeout cycle coinciding: pready wins; r_opc = pslverr.
- RESP:
  - psel=penable=0; r_valid=1 for exactly one cycle. Next state IDLE.
  - gnt=0 in RESP, even if req is high.
- Response registers:
  - r_rdata and r_opc hold their values until the next capture.
  - r_valid is 0 in every state except RESP.
- APB outputs: paddr, pwrite, pwdata and pstrb are stable from SETUP through the end of ACCESS, per the APB spec. They hold their value in IDLE.
- Latency:
  - Zero-wait-state slave: gnt at cycle 0, SETUP at 1, ACCESS at 2, r_valid at 3.
  - Each pready=0 cycle adds one cycle.
  - Minimum issue interval is 4 cycles.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1; it saturates and never wraps.
- Address: passed through unmodified. No alignment check; misalignment is the core's responsibility.
- req dropped without gnt: legal, nothing happens. req held high after RESP: regranted in the following IDLE cycle.

Decomposition:
- Package fc_tcdm_apb_pkg holds:
  - the state enum type (IDLE/SETUP/ACCESS/RESP, 2 bits);
  - the localparam for BE width.
- No sub-module: the FSM, capture registers and counter belong in one module.

Test Plan:
- Read, zero wait: req, add=0x1A10_4000, wen=1; prdata=0xDEAD_BEEF, pready=1 -> gnt at cycle 0; psel at 1–2; penable at 2; r_valid at 3 with rdata=0xDEAD_BEEF, opc=0.
- Write, be=4'b0110, wdata=0x1234_5678, 3 pready=0 cycles -> pwrite=1, pstrb=0110, pwdata stable through ACCESS; r_valid at cycle 6 with rdata=0, opc=0.
- Read with pslverr=1 at pready -> r_valid with opc=1 and rdata=prdata.
- TIMEOUT_CYCLES=4, pready held 0 -> penable high for exactly 4 cycles; r_valid with opc=1, rdata=0; psel drops in RESP.
- req held high for 3 back-to-back reads -> gnt only at cycles 0, 4, 8; three r_valid pulses at 3, 7, 11.
- rst_ni asserted during ACCESS -> psel, penable and r_valid go to 0 asynchronously; after release the FSM is IDLE, and a new req is granted the same cycle.
